// File: rtl/t3maps_pkg.sv
// ---------------------------------------------------------------------------
// t3maps_pkg
// Shared definitions for the T3MAPS control path.
//   CMD_*    : control codes recognised in the received byte stream
//   state_t  : command buffer state encoding (IDLE/LOAD/SHIFT/TX)
// ---------------------------------------------------------------------------
package t3maps_pkg;

   localparam logic [7:0] CMD_LOAD  = 8'hFF;  // begin loading a pattern
   localparam logic [7:0] CMD_END   = 8'hFE;  // end of pattern load
   localparam logic [7:0] CMD_SHIFT = 8'h7F;  // shift pattern out to the chip
   localparam logic [7:0] CMD_TX    = 8'h7E;  // echo pattern over UART TX

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_TX    = 2'd3
   } state_t;

endpackage

// File: rtl/t3maps_byte_ram.sv
// ---------------------------------------------------------------------------
// t3maps_byte_ram
// Single-port DEPTH x 8 synchronous RAM, registered read (1-cycle latency).
// A write returns the old contents on rdata (read-first).
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data
// ---------------------------------------------------------------------------
module t3maps_byte_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/t3maps_cmd_buffer.sv
// ---------------------------------------------------------------------------
// t3maps_cmd_buffer
// Byte-level command decoder and pattern buffer behind the UART receiver.
// Loads data bytes into a buffer between 0xFF/0xFE and replays them either
// as a serial stream to the chip (0x7F) or back over the UART TX (0x7E).
//   CLK, Reset          : clock, asynchronous active-high reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   tx_data, tx_valid,
//   tx_ready            : byte stream to the UART transmitter
//   shift_clk,
//   shift_data,
//   shift_load          : serial interface to the chip, MSB first
//   cmd, cmd_valid      : last plain byte seen in IDLE and its update pulse
//   count               : bytes currently stored
//   state               : current FSM state (IDLE=0 LOAD=1 SHIFT=2 TX=3)
//   overflow            : sticky, a byte was dropped with the buffer full
// ---------------------------------------------------------------------------
module t3maps_cmd_buffer
   import t3maps_pkg::*;
#(
   parameter int DEPTH     = 64,
   parameter int AW        = 6,
   parameter int SHIFT_DIV = 4
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          shift_clk,
   output logic          shift_data,
   output logic          shift_load,
   output logic [7:0]    cmd,
   output logic          cmd_valid,
   output logic [AW:0]   count,
   output logic [1:0]    state,
   output logic          overflow
);

   localparam int            DW       = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE      = (AW+1)'(1);

   state_t        state_q, state_d;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_idx;
   logic [AW:0]   byte_idx;
   logic [AW:0]   next_idx;
   logic [7:0]    shift_reg;

   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_rdata;

   logic          is_load, is_end, is_shift, is_tx;
   logic          half_done, last_bit, last_byte, shift_done, tx_accept;

   assign is_load  = (rx_data == CMD_LOAD);
   assign is_end   = (rx_data == CMD_END);
   assign is_shift = (rx_data == CMD_SHIFT);
   assign is_tx    = (rx_data == CMD_TX);

   assign next_idx   = byte_idx + ONE;
   assign half_done  = (div_cnt == DIV_LAST);
   assign last_bit   = (bit_idx == 3'd7);
   // Only meaningful in SHIFT/TX, which are entered with count > 0.
   assign last_byte  = (byte_idx == count - ONE);
   assign shift_done = (state_q == ST_SHIFT) && half_done && shift_clk &&
                       last_bit && last_byte;

   // Transmit handshake: a byte transfers on every cycle where tx_valid and
   // tx_ready are both high at the rising edge. Once raised, tx_valid and
   // tx_data hold until that transfer; tx_ready may toggle freely.
   assign tx_accept = (state_q == ST_TX) && tx_valid && tx_ready;

   assign shift_data = shift_reg[7];
   assign state      = state_q;

   // ---------------- state register ----------------
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               if (is_load) begin
                  state_d = ST_LOAD;
               end else if (is_shift && (count != '0)) begin
                  state_d = ST_SHIFT;
               end else if (is_tx && (count != '0)) begin
                  state_d = ST_TX;
               end
            end
         end
         ST_LOAD: begin
            if (rx_valid && is_end) begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (shift_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_TX: begin
            if (tx_accept && last_byte) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- RAM control ----------------
   // Outside a replay the RAM keeps reading address 0, so byte 0 is already
   // on ram_rdata when a replay starts. During a replay it reads the next
   // byte ahead; on the last byte it returns to address 0 so that a replay
   // requested right after this one also finds byte 0 ready.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      case (state_q)
         ST_LOAD: begin
            if (rx_valid && !is_end && (count != FULL)) begin
               ram_we   = 1'b1;
               ram_addr = count[AW-1:0];
            end
         end
         ST_SHIFT, ST_TX: begin
            if (!last_byte) begin
               ram_addr = next_idx[AW-1:0];
            end
         end
         default: ram_addr = '0;
      endcase
   end

   t3maps_byte_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (rx_data),
      .rdata (ram_rdata)
   );

   // ---------------- registered outputs / datapath ----------------
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         shift_clk  <= 1'b0;
         shift_load <= 1'b0;
         shift_reg  <= '0;
         cmd        <= '0;
         cmd_valid  <= 1'b0;
         count      <= '0;
         overflow   <= 1'b0;
         div_cnt    <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
      end else begin
         cmd_valid  <= 1'b0;
         shift_load <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rx_valid) begin
                  if (is_load) begin
                     count    <= '0;
                     overflow <= 1'b0;
                  end else if (is_shift) begin
                     if (count == '0) begin
                        shift_load <= 1'b1;
                     end else begin
                        // First bit is on shift_data from the first SHIFT cycle.
                        shift_reg <= ram_rdata;
                        shift_clk <= 1'b0;
                        div_cnt   <= '0;
                        bit_idx   <= '0;
                        byte_idx  <= '0;
                     end
                  end else if (is_tx) begin
                     if (count != '0) begin
                        tx_data  <= ram_rdata;
                        tx_valid <= 1'b1;
                        byte_idx <= '0;
                     end
                  end else if (!is_end) begin
                     cmd       <= rx_data;
                     cmd_valid <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               if (rx_valid && !is_end) begin
                  if (count == FULL) begin
                     overflow <= 1'b1;
                  end else begin
                     count <= count + ONE;
                  end
               end
            end

            ST_SHIFT: begin
               if (!half_done) begin
                  div_cnt <= div_cnt + DIV_ONE;
               end else begin
                  div_cnt <= '0;
                  if (!shift_clk) begin
                     shift_clk <= 1'b1;
                  end else begin
                     // End of the high half: falling edge, data moves on.
                     shift_clk <= 1'b0;
                     if (!last_bit) begin
                        bit_idx   <= bit_idx + 3'd1;
                        shift_reg <= {shift_reg[6:0], 1'b0};
                     end else if (!last_byte) begin
                        bit_idx   <= '0;
                        byte_idx  <= next_idx;
                        shift_reg <= ram_rdata;
                     end else begin
                        shift_reg  <= '0;
                        shift_load <= 1'b1;
                     end
                  end
               end
            end

            ST_TX: begin
               if (tx_valid) begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     if (!last_byte) begin
                        byte_idx <= next_idx;
                     end
                  end
               end else begin
                  // One idle cycle after each accept, then the prefetched byte.
                  tx_data  <= ram_rdata;
                  tx_valid <= 1'b1;
               end
            end

            default: ;
         endcase
      end
   end

endmodule
